// File: rtl/pixel_phase_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_phase_tracker_pkg
// Purpose  : Shared types and widths for the pixel-clock phase tracker
//            (tracking-state encoding, counter widths).
// Revision : 1.0 - initial parametrised release
// ============================================================================
package pixel_phase_tracker_pkg;

  // Tracker lock state
  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } track_state_t;

  localparam int SLIP_W = 8;  // slipCount width (saturates at 255)
  localparam int GOOD_W = 8;  // good-edge counter, holds LOCK_COUNT-1 (<=254)
  localparam int ERR_W  = 4;  // error counter, holds UNLOCK_ERRS-1 (<=14)

endpackage
`default_nettype wire

// File: rtl/pixel_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : pixel_edge_sync
// Purpose  : Three-flop synchroniser for an asynchronous input with a
//            one-cycle rising-edge pulse taken from the two settled stages.
// Ports    : clk      - sampling clock
//            rst_n    - synchronous active-low reset, clears all stages
//            async_in - asynchronous input
//            rise     - one-cycle pulse on a synchronised rising edge
// Revision : 1.0 - initial release
// ============================================================================
module pixel_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // s1 may be metastable; only the settled stages feed the detector.
  assign rise = s2 & ~s3;

endmodule
`default_nettype wire

// File: rtl/pixel_phase_tracker.sv
`default_nettype none
// ============================================================================
// Module   : pixel_phase_tracker
// Purpose  : Aligns a free-running mod-RATIO phase counter, clocked by the
//            PLL-multiplied system clock, to the rising edges of the raw
//            pixel clock. Provides lock acquisition, holdover through bad
//            edges, missing-clock detection and a saturating slip counter.
// Ports    : pixelClockXN    - system clock (RATIO x pixel clock)
//            nReset          - synchronous active-low reset
//            pixelClockIn    - raw asynchronous pixel clock
//            pixelClockPhase - current phase 0..RATIO-1
//            pixelClockX1_en - one-cycle pulse coincident with phase 0
//            locked          - high while in the LOCKED state
//            slipCount       - saturating count of phase-changing realigns
// Revision : 1.0 - initial parametrised release
// ============================================================================
module pixel_phase_tracker
  import pixel_phase_tracker_pkg::*;
#(
  parameter  int RATIO       = 6,
  parameter  int EDGE_OFFSET = 0,
  parameter  int LOCK_COUNT  = 16,
  parameter  int UNLOCK_ERRS = 4,
  localparam int PHASE_W     = $clog2(RATIO)
) (
  input  logic               pixelClockXN,
  input  logic               nReset,
  input  logic               pixelClockIn,
  output logic [PHASE_W-1:0] pixelClockPhase,
  output logic               pixelClockX1_en,
  output logic               locked,
  output logic [SLIP_W-1:0]  slipCount
);

  localparam int WD_W = $clog2(2 * RATIO);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(RATIO - 1);
  localparam logic [PHASE_W-1:0] PHASE_LOAD = PHASE_W'(EDGE_OFFSET);
  localparam logic [WD_W-1:0]    WD_LAST    = WD_W'(2 * RATIO - 1);
  localparam logic [GOOD_W-1:0]  GOOD_LAST  = GOOD_W'(LOCK_COUNT - 1);
  localparam logic [ERR_W-1:0]   ERR_LAST   = ERR_W'(UNLOCK_ERRS - 1);

  logic               pix_edge;
  logic [PHASE_W-1:0] natural_next;
  logic [PHASE_W-1:0] phase_next;
  logic               edge_good;
  logic               missing;
  logic               realign;
  logic [WD_W-1:0]    wd_cnt;
  track_state_t       state;
  track_state_t       state_next;
  logic [GOOD_W-1:0]  good_cnt;
  logic [GOOD_W-1:0]  good_cnt_next;
  logic [ERR_W-1:0]   err_cnt;
  logic [ERR_W-1:0]   err_cnt_next;

  pixel_edge_sync u_edge_sync (
    .clk      (pixelClockXN),
    .rst_n    (nReset),
    .async_in (pixelClockIn),
    .rise     (pix_edge)
  );

  assign natural_next = (pixelClockPhase == PHASE_LAST) ? '0
                                                        : pixelClockPhase + PHASE_W'(1);
  // An edge is good when it lands where the counter is already heading.
  assign edge_good    = pix_edge && (natural_next == PHASE_LOAD);
  // An edge arriving on the expiry cycle takes priority over the timeout.
  assign missing      = !pix_edge && (wd_cnt == WD_LAST);
  assign phase_next   = realign ? PHASE_LOAD : natural_next;

  always_comb begin
    state_next    = state;
    good_cnt_next = good_cnt;
    err_cnt_next  = err_cnt;
    realign       = 1'b0;
    case (state)
      SEARCH: begin
        if (pix_edge) begin
          realign       = 1'b1;
          good_cnt_next = '0;
          state_next    = ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (edge_good) begin
          if (good_cnt == GOOD_LAST) begin
            good_cnt_next = '0;
            err_cnt_next  = '0;
            state_next    = LOCKED;
          end else begin
            good_cnt_next = good_cnt + GOOD_W'(1);
          end
        end else if (pix_edge) begin
          realign       = 1'b1;
          good_cnt_next = '0;
        end else if (missing) begin
          state_next = SEARCH;
        end
      end
      LOCKED: begin
        // Holdover: the phase free-runs, bad events only accumulate.
        if (edge_good) begin
          err_cnt_next = '0;
        end else if (pix_edge || missing) begin
          if (err_cnt == ERR_LAST) begin
            err_cnt_next = '0;
            state_next   = SEARCH;
          end else begin
            err_cnt_next = err_cnt + ERR_W'(1);
          end
        end
      end
      default: begin
        state_next = SEARCH;
      end
    endcase
  end

  always_ff @(posedge pixelClockXN) begin
    if (!nReset) begin
      state           <= SEARCH;
      good_cnt        <= '0;
      err_cnt         <= '0;
      wd_cnt          <= '0;
      pixelClockPhase <= '0;
      pixelClockX1_en <= 1'b0;
      locked          <= 1'b0;
      slipCount       <= '0;
    end else begin
      state           <= state_next;
      good_cnt        <= good_cnt_next;
      err_cnt         <= err_cnt_next;
      wd_cnt          <= (pix_edge || missing) ? '0 : wd_cnt + WD_W'(1);
      pixelClockPhase <= phase_next;
      pixelClockX1_en <= (phase_next == '0);
      locked          <= (state_next == LOCKED);
      // Only realigns that actually move the phase count as a slip.
      if (realign && (PHASE_LOAD != natural_next) && (slipCount != '1)) begin
        slipCount <= slipCount + SLIP_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_phase_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_phase_tracker
// Purpose  : Self-checking bench for pixel_phase_tracker. Two instances:
//            A (RATIO=6, EDGE_OFFSET=0) and B (RATIO=4, EDGE_OFFSET=3), each
//            compared every cycle with a behavioural model of the tracking
//            rules, plus fixed expectations at the documented boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_phase_tracker;

  localparam int M_SEARCH = 0;
  localparam int M_ACQ    = 1;
  localparam int M_LOCK   = 2;

  typedef struct {
    bit q0, q1, q2;   // history of input samples, newest first
    int phase;
    bit x1;
    bit lk;
    int slip;
    int mode;
    int good;
    int err;
    int since;        // cycles since last edge / timeout
  } mdl_t;

  logic       clk = 1'b0;
  logic       rn_a, in_a, rn_b, in_b;
  logic [2:0] ph_a;
  logic [1:0] ph_b;
  logic       x1_a, lk_a, x1_b, lk_b;
  logic [7:0] sl_a, sl_b;
  mdl_t       ma, mb;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  pixel_phase_tracker #(.RATIO(6), .EDGE_OFFSET(0), .LOCK_COUNT(16), .UNLOCK_ERRS(4)) dut_a (
    .pixelClockXN(clk), .nReset(rn_a), .pixelClockIn(in_a),
    .pixelClockPhase(ph_a), .pixelClockX1_en(x1_a), .locked(lk_a), .slipCount(sl_a));

  pixel_phase_tracker #(.RATIO(4), .EDGE_OFFSET(3), .LOCK_COUNT(16), .UNLOCK_ERRS(4)) dut_b (
    .pixelClockXN(clk), .nReset(rn_b), .pixelClockIn(in_b),
    .pixelClockPhase(ph_b), .pixelClockX1_en(x1_b), .locked(lk_b), .slipCount(sl_b));

  // One system-clock step of the tracking rules.
  function automatic mdl_t step(input mdl_t m, input int R, input int OFF, input int LC,
                                input int UE, input bit rst_n, input bit din);
    mdl_t n;
    bit   e, gd, miss, re;
    int   nat;
    n = m;
    if (!rst_n) begin
      n = '{default: 0};
      return n;
    end
    e    = m.q1 && !m.q2;
    nat  = (m.phase + 1) % R;
    gd   = e && (nat == OFF);
    miss = !e && (m.since == 2 * R - 1);
    n.since = (e || miss) ? 0 : m.since + 1;
    re = 0;
    case (m.mode)
      M_SEARCH: if (e) begin re = 1; n.good = 0; n.mode = M_ACQ; end
      M_ACQ: begin
        if (gd) begin
          n.good = m.good + 1;
          if (n.good == LC) begin n.mode = M_LOCK; n.err = 0; end
        end else if (e) begin
          re = 1; n.good = 0;
        end else if (miss) begin
          n.mode = M_SEARCH;
        end
      end
      default: begin
        if (gd) n.err = 0;
        else if (e || miss) begin
          n.err = m.err + 1;
          if (n.err == UE) n.mode = M_SEARCH;
        end
      end
    endcase
    n.phase = re ? OFF : nat;
    if (re && OFF != nat && m.slip < 255) n.slip = m.slip + 1;
    n.x1 = (n.phase == 0);
    n.lk = (n.mode == M_LOCK);
    n.q2 = m.q1;
    n.q1 = m.q0;
    n.q0 = din;
    return n;
  endfunction

  task automatic tick();
    ma = step(ma, 6, 0, 16, 4, rn_a, in_a);
    mb = step(mb, 4, 3, 16, 4, rn_b, in_b);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rn_a = 0; rn_b = 0; in_a = 1; in_b = 1;
    repeat (3) tick();
    total++;
    if ({ph_a, x1_a, lk_a, sl_a} !== 13'd0) begin
      bad++;
      $display("FAIL reset_a got ph=%0d x1=%0b lk=%0b slip=%0d want all 0", ph_a, x1_a, lk_a, sl_a);
    end
    total++;
    if ({ph_b, x1_b, lk_b, sl_b} !== 12'd0) begin
      bad++;
      $display("FAIL reset_b got ph=%0d x1=%0b lk=%0b slip=%0d want all 0", ph_b, x1_b, lk_b, sl_b);
    end
    in_a = 0; in_b = 0; rn_a = 1; rn_b = 1;
  endtask

  task automatic test_acquire();
    int off;
    off = $urandom_range(0, 5);
    for (int i = 0; i < off; i++) tick();
    for (int p = 0; p < 20; p++) begin
      for (int c = 0; c < 6; c++) begin
        in_a = (c < 3);
        tick();
        total++;
        if (ph_a !== 3'(ma.phase) || x1_a !== ma.x1 || lk_a !== ma.lk || sl_a !== 8'(ma.slip)) begin
          bad++;
          $display("FAIL acquire p=%0d c=%0d got ph=%0d x1=%0b lk=%0b slip=%0d want ph=%0d x1=%0b lk=%0b slip=%0d",
                   p, c, ph_a, x1_a, lk_a, sl_a, ma.phase, ma.x1, ma.lk, ma.slip);
        end
        // Aligned input: phase 0 and the enable follow each edge directly.
        if (c == 2) begin
          total++;
          if (ph_a !== 3'd0 || x1_a !== 1'b1) begin
            bad++;
            $display("FAIL acquire_phase0 p=%0d got ph=%0d x1=%0b want ph=0 x1=1", p, ph_a, x1_a);
          end
        end
      end
    end
    total++;
    if (lk_a !== 1'b1 || sl_a > 8'd1) begin
      bad++;
      $display("FAIL acquire_end got lk=%0b slip=%0d want lk=1 slip<=1", lk_a, sl_a);
    end
  endtask

  task automatic test_step();
    int slip0;
    slip0 = sl_a;
    in_a = 0;
    repeat (2) tick();
    for (int p = 0; p < 24; p++) begin
      for (int c = 0; c < 6; c++) begin
        in_a = (c < 3);
        tick();
        total++;
        if (ph_a !== 3'(ma.phase) || x1_a !== ma.x1 || lk_a !== ma.lk || sl_a !== 8'(ma.slip)) begin
          bad++;
          $display("FAIL step p=%0d c=%0d got ph=%0d x1=%0b lk=%0b slip=%0d want ph=%0d x1=%0b lk=%0b slip=%0d",
                   p, c, ph_a, x1_a, lk_a, sl_a, ma.phase, ma.x1, ma.lk, ma.slip);
        end
      end
    end
    total++;
    if (lk_a !== 1'b1 || sl_a !== 8'(slip0 + 1)) begin
      bad++;
      $display("FAIL step_end got lk=%0b slip=%0d want lk=1 slip=%0d", lk_a, sl_a, slip0 + 1);
    end
  endtask

  task automatic test_glitch();
    int slip0;
    slip0 = sl_a;
    for (int p = 0; p < 8; p++) begin
      for (int c = 0; c < 6; c++) begin
        in_a = (c < 3) || (p == 3 && c == 4);
        tick();
        total++;
        if (ph_a !== 3'(ma.phase) || x1_a !== ma.x1 || lk_a !== 1'b1 || sl_a !== 8'(slip0)) begin
          bad++;
          $display("FAIL glitch p=%0d c=%0d got ph=%0d x1=%0b lk=%0b slip=%0d want ph=%0d x1=%0b lk=1 slip=%0d",
                   p, c, ph_a, x1_a, lk_a, sl_a, ma.phase, ma.x1, slip0);
        end
      end
    end
  endtask

  task automatic test_stuck_low();
    in_a = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      total++;
      if (ph_a !== 3'(ma.phase) || x1_a !== ma.x1 || lk_a !== ma.lk || sl_a !== 8'(ma.slip)) begin
        bad++;
        $display("FAIL stuck_low i=%0d got ph=%0d x1=%0b lk=%0b slip=%0d want ph=%0d x1=%0b lk=%0b slip=%0d",
                 i, ph_a, x1_a, lk_a, sl_a, ma.phase, ma.x1, ma.lk, ma.slip);
      end
    end
    total++;
    if (lk_a !== 1'b0) begin
      bad++;
      $display("FAIL stuck_low_end got lk=%0b want lk=0", lk_a);
    end
  endtask

  task automatic test_saturate();
    int per;
    int pers[4] = '{4, 5, 7, 8};
    rn_a = 0; in_a = 0;
    tick();
    rn_a = 1;
    for (int e = 0; e < 300; e++) begin
      per = pers[$urandom_range(0, 3)];
      for (int c = 0; c < per; c++) begin
        in_a = (c < per / 2);
        tick();
        total++;
        if (ph_a !== 3'(ma.phase) || x1_a !== ma.x1 || lk_a !== 1'b0 || sl_a !== 8'(ma.slip)) begin
          bad++;
          $display("FAIL saturate e=%0d c=%0d got ph=%0d x1=%0b lk=%0b slip=%0d want ph=%0d x1=%0b lk=0 slip=%0d",
                   e, c, ph_a, x1_a, lk_a, sl_a, ma.phase, ma.x1, ma.slip);
        end
      end
    end
    total++;
    if (sl_a !== 8'd255) begin
      bad++;
      $display("FAIL saturate_end got slip=%0d want 255", sl_a);
    end
  endtask

  task automatic test_ratio4();
    for (int run = 0; run < 2; run++) begin
      for (int p = 0; p < 20; p++) begin
        for (int c = 0; c < 4; c++) begin
          in_b = (c < 2);
          tick();
          total++;
          if (ph_b !== 2'(mb.phase) || x1_b !== mb.x1 || lk_b !== mb.lk || sl_b !== 8'(mb.slip)) begin
            bad++;
            $display("FAIL ratio4 r=%0d p=%0d c=%0d got ph=%0d x1=%0b lk=%0b slip=%0d want ph=%0d x1=%0b lk=%0b slip=%0d",
                     run, p, c, ph_b, x1_b, lk_b, sl_b, mb.phase, mb.x1, mb.lk, mb.slip);
          end
          // Aligned edge loads 3; the enable follows one cycle later at phase 0.
          if (c == 2 || c == 3) begin
            total++;
            if (ph_b !== ((c == 2) ? 2'd3 : 2'd0) || x1_b !== (c == 3)) begin
              bad++;
              $display("FAIL ratio4_seq p=%0d c=%0d got ph=%0d x1=%0b want ph=%0d x1=%0b",
                       p, c, ph_b, x1_b, (c == 2) ? 3 : 0, (c == 3));
            end
          end
        end
      end
      total++;
      if (lk_b !== 1'b1) begin
        bad++;
        $display("FAIL ratio4_lock r=%0d got lk=%0b want 1", run, lk_b);
      end
      if (run == 0) begin
        rn_b = 0; in_b = 1;
        tick();
        rn_b = 1; in_b = 0;
        total++;
        if ({ph_b, x1_b, lk_b, sl_b} !== 12'd0) begin
          bad++;
          $display("FAIL ratio4_reset got ph=%0d x1=%0b lk=%0b slip=%0d want all 0", ph_b, x1_b, lk_b, sl_b);
        end
        // Re-enter the period with the line already low.
        tick();
        tick();
      end
    end
  endtask

  task automatic test_back_to_back();
    int hold_a = 0;
    int hold_b = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold_a == 0) begin in_a = 1'($urandom_range(0, 1)); hold_a = $urandom_range(1, 9); end
      if (hold_b == 0) begin in_b = 1'($urandom_range(0, 1)); hold_b = $urandom_range(1, 7); end
      hold_a--;
      hold_b--;
      rn_a = ($urandom_range(0, 199) != 0);
      rn_b = ($urandom_range(0, 199) != 0);
      tick();
      total++;
      if (ph_a !== 3'(ma.phase) || x1_a !== ma.x1 || lk_a !== ma.lk || sl_a !== 8'(ma.slip)) begin
        bad++;
        $display("FAIL random_a i=%0d got ph=%0d x1=%0b lk=%0b slip=%0d want ph=%0d x1=%0b lk=%0b slip=%0d",
                 i, ph_a, x1_a, lk_a, sl_a, ma.phase, ma.x1, ma.lk, ma.slip);
      end
      total++;
      if (ph_b !== 2'(mb.phase) || x1_b !== mb.x1 || lk_b !== mb.lk || sl_b !== 8'(mb.slip)) begin
        bad++;
        $display("FAIL random_b i=%0d got ph=%0d x1=%0b lk=%0b slip=%0d want ph=%0d x1=%0b lk=%0b slip=%0d",
                 i, ph_b, x1_b, lk_b, sl_b, mb.phase, mb.x1, mb.lk, mb.slip);
      end
    end
  endtask

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    rn_a = 0; rn_b = 0; in_a = 0; in_b = 0;
    test_reset();
    test_acquire();
    test_step();
    test_glitch();
    test_stuck_low();
    test_saturate();
    test_ratio4();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
